// File: rtl/adc_frame_capture_if.sv
// Byte-stream handshake from the frame capture unit to the UART transmitter.
// A byte moves on every cycle where tx_valid and tx_ready are both high.
interface adc_frame_capture_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_frame_capture.sv
// Multi-channel ADC frame capture: converts samples to inverted 8-bit display codes,
// buffers one frame, then streams header + data + checksum over a byte handshake.
module adc_frame_capture #(
    parameter int         CH_NUM  = 2,
    parameter int         ADC_W   = 12,
    parameter int         DEPTH   = 400,
    parameter int         SPAN    = 95,
    parameter int         HOLDOFF = 5_000_000,
    parameter logic [7:0] HDR     = 8'hA5
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    trig_pol,
    input  logic                    half_rate,
    input  logic                    adc_valid,
    input  logic [CH_NUM*ADC_W-1:0] adc_data,
    input  logic [CH_NUM*8-1:0]     offset,
    adc_frame_capture_if.master     tx,
    output logic [2:0]              state,
    output logic                    busy,
    output logic                    overrun
);
    localparam int NB  = CH_NUM * DEPTH;
    localparam int AW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW  = $clog2(DEPTH + 1);
    localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CW  = $clog2(2 * CH_NUM);
    localparam int SW  = $clog2(NB + 2);
    localparam int HW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SEND    = 3'd2,
        ST_DONE    = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Offset removal, clamping and inverted scaling of one 8-bit sample.
    function automatic logic [7:0] conv_code(input logic [7:0] v, input logic [7:0] off);
        logic signed [9:0] d;
        logic [17:0]       num;
        logic [17:0]       quo;
        d = $signed({2'b00, v}) - $signed({2'b00, off});
        if (d <= 0) begin
            return 8'hFF;
        end else if (d >= $signed(10'(SPAN))) begin
            return 8'h00;
        end
        num = 18'($unsigned(d)) * 18'd255 + 18'(SPAN / 2);
        quo = num / 18'(SPAN);
        return 8'd255 - quo[7:0];
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            burst_q, burst_d;
    logic            ovr_q, ovr_d;
    logic            hr_q, hr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [SW-1:0]   sidx_q, sidx_d;
    logic            ld_q, ld_d;
    logic [7:0]      csum_q, csum_d;
    logic            txv_q, txv_d;
    logic [7:0]      txd_q, txd_d;

    logic [7:0]      off_q   [CH_NUM];
    logic [7:0]      codes_d [CH_NUM];
    logic [7:0]      codes_q [CH_NUM];
    logic [7:0]      frame_mem [NB];
    logic [7:0]      rd_data_q;

    logic            arm, xfer, arm_take, accept, wr_en, dup;
    logic [CHW-1:0]  wr_ch;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [SW-1:0]   ridx;
    logic            unused_adc_lsbs;

    assign arm             = start ^ trig_pol;
    assign xfer            = txv_q & tx.tx_ready;
    assign unused_adc_lsbs = ^adc_data;

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            codes_d[c] = conv_code(adc_data[c*ADC_W + ADC_W - 8 +: 8], off_q[c]);
        end
    end

    // The read address looks one byte ahead during a transfer so the next
    // byte is ready to load on the very next cycle.
    always_comb begin
        dup     = hr_q & wr_cnt_q[0];
        wr_ch   = CHW'(hr_q ? (wr_cnt_q >> 1) : wr_cnt_q);
        wr_addr = AW'(32'(wr_ch) * 32'(DEPTH) + 32'(idx_q) + 32'(dup));
        ridx    = xfer ? sidx_q : sidx_q - SW'(1);
        rd_addr = (ridx < SW'(NB)) ? AW'(ridx) : '0;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_cnt_d = wr_cnt_q;
        burst_d  = burst_q;
        ovr_d    = ovr_q;
        hr_d     = hr_q;
        hold_d   = hold_q;
        sidx_d   = sidx_q;
        ld_d     = ld_q;
        csum_d   = csum_q;
        txv_d    = txv_q;
        txd_d    = txd_q;
        arm_take = 1'b0;
        accept   = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_CAPTURE;
                    arm_take = 1'b1;
                    hr_d     = half_rate;
                    idx_d    = '0;
                    wr_cnt_d = '0;
                    burst_d  = 1'b0;
                    ovr_d    = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (!arm) begin
                    state_d  = ST_IDLE;
                    burst_d  = 1'b0;
                    wr_cnt_d = '0;
                    idx_d    = '0;
                end else begin
                    if (adc_valid) begin
                        if (burst_q) begin
                            ovr_d = 1'b1;
                        end else begin
                            accept   = 1'b1;
                            burst_d  = 1'b1;
                            wr_cnt_d = '0;
                        end
                    end
                    if (burst_q) begin
                        wr_en = 1'b1;
                        if (wr_cnt_q == (hr_q ? CW'(2*CH_NUM - 1) : CW'(CH_NUM - 1))) begin
                            burst_d  = 1'b0;
                            wr_cnt_d = '0;
                            idx_d    = idx_q + (hr_q ? IW'(2) : IW'(1));
                            if (idx_d >= IW'(DEPTH)) begin
                                state_d = ST_HOLD;
                                hold_d  = '0;
                            end
                        end else begin
                            wr_cnt_d = wr_cnt_q + CW'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    idx_d   = '0;
                end else if (hold_q == HW'(HOLDOFF - 1)) begin
                    state_d = ST_SEND;
                    hold_d  = '0;
                    sidx_d  = '0;
                    ld_d    = 1'b0;
                    txv_d   = 1'b0;
                    csum_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_SEND: begin
                // Byte index 0 is the header, 1..NB the buffer, NB+1 the checksum.
                if (xfer) begin
                    txv_d = 1'b0;
                    if (sidx_q != '0 && sidx_q <= SW'(NB)) begin
                        csum_d = csum_q + txd_q;
                    end
                    if (sidx_q == SW'(NB + 1)) begin
                        state_d = ST_DONE;
                        ld_d    = 1'b0;
                    end else begin
                        sidx_d = sidx_q + SW'(1);
                        ld_d   = 1'b1;
                    end
                end else if (ld_q) begin
                    ld_d  = 1'b0;
                    txv_d = 1'b1;
                    if (sidx_q == '0) begin
                        txd_d = HDR;
                    end else if (sidx_q == SW'(NB + 1)) begin
                        txd_d = csum_q;
                    end else begin
                        txd_d = rd_data_q;
                    end
                end else if (!txv_q) begin
                    ld_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            wr_cnt_q <= '0;
            burst_q  <= 1'b0;
            ovr_q    <= 1'b0;
            hr_q     <= 1'b0;
            hold_q   <= '0;
            sidx_q   <= '0;
            ld_q     <= 1'b0;
            csum_q   <= '0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_cnt_q <= wr_cnt_d;
            burst_q  <= burst_d;
            ovr_q    <= ovr_d;
            hr_q     <= hr_d;
            hold_q   <= hold_d;
            sidx_q   <= sidx_d;
            ld_q     <= ld_d;
            csum_q   <= csum_d;
            txv_q    <= txv_d;
            txd_q    <= txd_d;
        end
    end

    // Datapath storage carries no reset; its contents are qualified by the FSM.
    always_ff @(posedge sys_clk) begin
        if (arm_take) begin
            for (int c = 0; c < CH_NUM; c++) begin
                off_q[c] <= offset[c*8 +: 8];
            end
        end
        if (accept) begin
            codes_q <= codes_d;
        end
        if (wr_en) begin
            frame_mem[wr_addr] <= codes_q[wr_ch];
        end
        rd_data_q <= frame_mem[rd_addr];
    end

    assign tx.tx_data  = txd_q;
    assign tx.tx_valid = txv_q;
    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = ovr_q;
endmodule

// File: doc/adc_frame_capture.md
# adc_frame_capture

Parametrised multi-channel ADC frame capture and byte-stream unit. On an armed start it captures `DEPTH` samples per channel from the ADC front end. Each sample is offset-compensated, clamped and scaled to an inverted 8-bit display code, then stored in an on-chip frame buffer. After a hold-off the frame is streamed out as header, data and checksum over a valid/ready byte handshake to the UART transmitter. It sits between the ADC sampling logic and the `tx` UART instances, and supports any channel count and depth plus an optional half-rate (sample-doubling) mode.

## Interface
- `CH_NUM`, 2, number of ADC channels
- `ADC_W`, 12, ADC sample width (≥ 8)
- `DEPTH`, 400, stored bytes per channel per frame (even)
- `SPAN`, 95, full-scale span in 8-bit codes after offset removal (1..255)
- `HOLDOFF`, 5_000_000, sys_clk cycles between capture end and transmit start
- `HDR`, 8'hA5, frame header byte
- `sys_clk`, in, 1, system clock; all logic on rising edge
- `rst_n`, in, 1, synchronous active-low reset
- `start`, in, 1, acquisition request level
- `trig_pol`, in, 1, start polarity; arm = start ^ trig_pol
- `half_rate`, in, 1, 1 = each acquisition stored twice (DEPTH/2 acquisitions)
- `adc_valid`, in, 1, one-cycle strobe: `adc_data` valid
- `adc_data`, in, CH_NUM*ADC_W, channel c at [c*ADC_W +: ADC_W]
- `offset`, in, CH_NUM*8, per-channel offset code, channel c at [c*8 +: 8]
- `tx_data`, out, 8, byte to UART
- `tx_valid`, out, 1, `tx_data` valid
- `tx_ready`, in, 1, UART accepts byte when high with `tx_valid`
- `state`, out, 3, FSM state
- `busy`, out, 1, state ≠ IDLE
- `overrun`, out, 1, sticky: an `adc_valid` was dropped this frame

## Operation
- States: IDLE=0, CAPTURE=1, HOLD=4, SEND=2, DONE=3.
- IDLE→CAPTURE when arm=1. `offset`, `half_rate` and the sample index are latched on this transition. `overrun` clears on this transition.
- CAPTURE: each accepted `adc_valid` performs CH_NUM buffer writes, one per cycle, or 2*CH_NUM writes in half_rate mode.
- Write address is c*DEPTH + idx. In half_rate mode the writes go to idx and idx+1, then idx advances by 2; otherwise idx advances by 1.
- When idx reaches DEPTH after a write burst, go to HOLD.
- An `adc_valid` arriving while a write burst is pending is dropped and sets `overrun`.
- Conversion per channel:
  - v = top 8 bits of sample; d = v − offset[c] (signed, 10 bit).
  - d ≤ 0 → 255.
  - d ≥ SPAN → 0.
  - else → 255 − round(d*255/SPAN), where round = floor((d*255 + SPAN/2)/SPAN).
- HOLD: counts HOLDOFF cycles, then goes to SEND.
- arm=0 during CAPTURE or HOLD aborts to IDLE. Buffer contents are don't-care.
- SEND: emits HDR, then buffer addresses 0..CH_NUM*DEPTH−1 in order, then an 8-bit modulo sum of all data bytes (header excluded). Then go to DONE. arm changes during SEND are ignored.
- DONE → IDLE when arm=0.
- Reset (any state, mid-frame included): state=IDLE, tx_valid=0, tx_data=0, busy=0, overrun=0, counters=0. Buffer contents are not reset.

## Timing
- Conversion is registered. The first buffer write occurs 1 cycle after `adc_valid`, and subsequent channel writes follow on consecutive cycles.
- Minimum `adc_valid` spacing without overrun: CH_NUM+1 cycles normal, 2*CH_NUM+1 cycles half_rate.
- Buffer read latency is 1 cycle. `tx_valid` rises no earlier than 2 cycles after entering SEND.
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. A byte transfers on the cycle with tx_valid & tx_ready.
- After each transfer, `tx_valid` drops for ≥1 cycle; the next byte is valid 2 cycles after the transfer.
- The last (checksum) transfer moves the FSM to DONE on the next edge, with tx_valid=0.
- `state` and `busy` update on the clock edge following the triggering condition.

## Test plan
- Arithmetic, half_rate=0: CH_NUM=2, DEPTH=8, HOLDOFF=10, SPAN=95, offset=80/80, `tx_ready` tied 1. Drive 8 strobes with ch0=12'h800, ch1=12'hB30. Expect stream A5, 8×7E (126), 8×00, checksum 8'hF0.
- Clamp low: ch0=12'h4D0 with offset 80 (d=−3). Expect bytes FF.
- Half-rate: DEPTH=8, half_rate=1, 4 strobes with ch0 values 12'h800, 12'h500, 12'h800, 12'h500. Expect ch0 bytes 7E,7E,FF,FF,7E,7E,FF,FF. Capture ends after the 4th burst.
- Overrun: two `adc_valid` pulses 1 cycle apart. Expect `overrun`=1, the second sample not stored, and idx advanced by 1.
- Backpressure and abort:
  - Hold `tx_ready`=0 for 20 cycles mid-SEND. Expect `tx_data` stable and no byte lost.
  - Drop arm during HOLD. Expect IDLE the next cycle with no bytes sent.
- Reset mid-SEND: assert rst_n=0 for one cycle. Expect state=0 and tx_valid=0 after that edge. A new arm restarts with the HDR byte first.
